// File: rtl/reaction_game_pkg.sv
// Shared state encoding and constant helpers for the reaction game controller.
package reaction_game_pkg;

  typedef enum logic [2:0] {
    S_MODE   = 3'd0,
    S_TARGET = 3'd1,
    S_COUNT  = 3'd2,
    S_SCORE  = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DOWN = 1;
  localparam int unsigned BTN_SEL  = 2;

  // Bits needed to hold n_values distinct codes; never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n_values);
    return (n_values > 1) ? $clog2(n_values) : 1;
  endfunction

  // Clock cycles per count step in a given mode; higher modes count faster.
  function automatic int unsigned mode_period(input int unsigned tick_base,
                                              input int unsigned num_modes,
                                              input int unsigned mode);
    return tick_base << (num_modes - 1 - mode);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a vector of debounced button levels.
// History resets high so a button held through reset must be released first.
module btn_edge #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] hist_q;
  logic [N-1:0] rise_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '1;
      rise_q <= '0;
    end else begin
      hist_q <= btn_i;
      rise_q <= btn_i & ~hist_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction game controller: mode select, target display, timed
// count, divider-free scoring onto an LED bar and best-error tracking.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int unsigned NUM_W        = 14,
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned TICK_BASE    = 100000,
  parameter int unsigned DEFAULT_MODE = 1,
  parameter int unsigned NUM_LEDS     = 16,
  parameter int unsigned LED_STEP     = 30,
  parameter int unsigned ROUNDS       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               btn_up,
  input  logic                               btn_down,
  input  logic                               btn_sel,
  input  logic [NUM_W-1:0]                   rand_in,
  output logic [2:0]                         state,
  output logic [width_of(NUM_MODES)-1:0]     mode,
  output logic [NUM_W-1:0]                   number,
  output logic [NUM_LEDS-1:0]                led,
  output logic [NUM_W-1:0]                   best_err,
  output logic [width_of(ROUNDS+1)-1:0]      round_idx,
  output logic                               round_done
);

  localparam int unsigned MODE_W = width_of(NUM_MODES);
  localparam int unsigned ROUND_W = width_of(ROUNDS + 1);
  localparam int unsigned OFF_W = width_of(NUM_LEDS + 1);
  localparam int unsigned TICK_W = width_of(mode_period(TICK_BASE, NUM_MODES, 0));
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  logic [2:0] rise;
  logic       up_rise, down_rise, sel_rise;

  state_e               state_q, state_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [NUM_W-1:0]     number_q, number_d;
  logic [NUM_W-1:0]     target_q, target_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic [NUM_W-1:0]     best_err_q, best_err_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 round_done_q, round_done_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [NUM_W-1:0]     err_q, err_d;
  logic [NUM_W-1:0]     rem_q, rem_d;
  logic [OFF_W-1:0]     off_q, off_d;

  logic [NUM_W-1:0]     fixed_rand;
  logic [NUM_W-1:0]     abs_diff;
  logic [TICK_W-1:0]    period_m1;
  logic [NUM_LEDS-1:0]  led_fin;

  btn_edge #(.N(3)) u_btn_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  ({btn_sel, btn_down, btn_up}),
    .rise_o (rise)
  );

  assign up_rise   = rise[BTN_UP];
  assign down_rise = rise[BTN_DOWN];
  assign sel_rise  = rise[BTN_SEL];

  // A zero target would make a perfect score trivial, so it is bumped to 1.
  assign fixed_rand = (rand_in == '0) ? NUM_W'(1) : rand_in;
  assign abs_diff   = (number_q >= target_q) ? (number_q - target_q)
                                             : (target_q - number_q);
  assign period_m1  = TICK_W'(mode_period(TICK_BASE, NUM_MODES, 32'(mode_q)) - 32'd1);

  // Bar with the lowest off LEDs extinguished; all dark once off reaches NUM_LEDS.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_fin[i] = (i >= int'(off_q));
    end
  end

  // NOTE: every signal written here gets its default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    number_d     = number_q;
    target_d     = target_q;
    led_d        = led_q;
    best_err_d   = best_err_q;
    round_d      = round_q;
    round_done_d = 1'b0;
    tick_d       = tick_q;
    err_d        = err_q;
    rem_d        = rem_q;
    off_d        = off_q;

    case (state_q)
      S_MODE: begin
        if (sel_rise) begin
          target_d   = fixed_rand;
          number_d   = fixed_rand;
          best_err_d = '1;
          round_d    = '0;
          led_d      = '0;
          state_d    = S_TARGET;
        end else if (up_rise && !down_rise && mode_q != MODE_MAX) begin
          mode_d = mode_q + MODE_W'(1);
        end else if (down_rise && !up_rise && mode_q != '0) begin
          mode_d = mode_q - MODE_W'(1);
        end
      end

      S_TARGET: begin
        if (sel_rise) begin
          number_d = '0;
          tick_d   = '0;
          state_d  = S_COUNT;
        end
      end

      S_COUNT: begin
        // A saturated count ends the round exactly like a player stop.
        if (sel_rise || number_q == '1) begin
          err_d   = abs_diff;
          rem_d   = abs_diff;
          off_d   = '0;
          state_d = S_SCORE;
        end else if (tick_q == period_m1) begin
          tick_d   = '0;
          number_d = number_q + NUM_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      S_SCORE: begin
        // Repeated subtraction stands in for err / LED_STEP, one step per cycle.
        if (32'(rem_q) >= LED_STEP && off_q < OFF_W'(NUM_LEDS)) begin
          rem_d = rem_q - NUM_W'(LED_STEP);
          off_d = off_q + OFF_W'(1);
        end else begin
          led_d        = led_fin;
          best_err_d   = (err_q < best_err_q) ? err_q : best_err_q;
          round_done_d = 1'b1;
          state_d      = S_RESULT;
        end
      end

      S_RESULT: begin
        if (sel_rise) begin
          if (round_q < ROUND_W'(ROUNDS - 1)) begin
            round_d  = round_q + ROUND_W'(1);
            target_d = fixed_rand;
            number_d = fixed_rand;
            led_d    = '0;
            state_d  = S_TARGET;
          end else begin
            state_d = S_MODE;
          end
        end
      end

      default: state_d = S_MODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_MODE;
      mode_q       <= MODE_W'(DEFAULT_MODE);
      number_q     <= '0;
      target_q     <= '0;
      led_q        <= '0;
      best_err_q   <= '1;
      round_q      <= '0;
      round_done_q <= 1'b0;
      tick_q       <= '0;
      err_q        <= '0;
      rem_q        <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      number_q     <= number_d;
      target_q     <= target_d;
      led_q        <= led_d;
      best_err_q   <= best_err_d;
      round_q      <= round_d;
      round_done_q <= round_done_d;
      tick_q       <= tick_d;
      err_q        <= err_d;
      rem_q        <= rem_d;
      off_q        <= off_d;
    end
  end

  assign state      = state_q;
  assign mode       = mode_q;
  assign number     = number_q;
  assign led        = led_q;
  assign best_err   = best_err_q;
  assign round_idx  = round_q;
  assign round_done = round_done_q;

endmodule
